// File: rtl/alu_operand_pipe_if.sv
// Valid/ready request and result-side bundle between the operand pipe, its
// producer (master) and the ALU-side consumer.
interface alu_operand_pipe_if #(
  parameter int unsigned W1  = 8,
  parameter int unsigned W2  = 32,
  parameter int unsigned OPW = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [W1-1:0]  in_num1;
  logic [W2-1:0]  in_num2;
  logic [OPW-1:0] in_op;
  logic           out_valid;
  logic           out_ready;
  logic [W1-1:0]  out_num1;
  logic [W2-1:0]  out_num2;
  logic [OPW-1:0] out_op;
  logic           out_rsvd;

  modport master (
    output in_valid, in_num1, in_num2, in_op, out_ready,
    input  in_ready, out_valid, out_num1, out_num2, out_op, out_rsvd
  );

  modport slave (
    input  in_valid, in_num1, in_num2, in_op, out_ready,
    output in_ready, out_valid, out_num1, out_num2, out_op, out_rsvd
  );
endinterface

// File: rtl/alu_operand_pipe.sv
// STAGES-deep valid/ready operand pipeline feeding the ALU, with global stall,
// flush, bubble collapse and reserved-opcode tagging.
module alu_operand_pipe #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned W1     = 8,
  parameter int unsigned W2     = 32,
  parameter int unsigned OPW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_pipe_if.slave    bus,
  input  logic                 stall,
  input  logic                 flush,
  output logic [3:0]           occupancy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [W1-1:0]     n1   [STAGES];
  logic [W2-1:0]     n2   [STAGES];
  logic [OPW-1:0]    op   [STAGES];
  logic              rsvd [STAGES];

  // A slot can take new data if it is empty or its occupant moves on this cycle.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !v[STAGES-1] | bus.out_ready;
    for (int unsigned k = STAGES - 1; k > 0; k--) begin
      rdy[k-1] = !v[k-1] | rdy[k];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occupancy = occupancy + 4'(v[k]);
    end
  end

  assign bus.in_ready  = rdy[0] & !stall & !flush;
  assign bus.out_valid = v[STAGES-1] & !stall;
  assign bus.out_num1  = n1[STAGES-1];
  assign bus.out_num2  = n2[STAGES-1];
  assign bus.out_op    = op[STAGES-1];
  assign bus.out_rsvd  = rsvd[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        n1[k]   <= '0;
        n2[k]   <= '0;
        op[k]   <= '0;
        rsvd[k] <= 1'b0;
      end
    end else if (flush) begin
      v <= '0;
    end else if (!stall) begin
      // Slot 0 takes in_valid directly: when rdy[0] holds here, in_ready is 1.
      if (rdy[0]) begin
        v[0]    <= bus.in_valid;
        n1[0]   <= bus.in_num1;
        n2[0]   <= bus.in_num2;
        op[0]   <= bus.in_op;
        rsvd[0] <= bus.in_op[2] & bus.in_op[1];
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k]    <= v[k-1];
          n1[k]   <= n1[k-1];
          n2[k]   <= n2[k-1];
          op[k]   <= op[k-1];
          rsvd[k] <= rsvd[k-1];
        end
      end
    end
  end

endmodule

// File: doc/alu_operand_pipe.md
Name: alu_operand_pipe

Overview:
- Parameterised valid/ready operand pipeline sitting directly upstream of the 8/32-bit ALU.
- Accepts operation requests (num1, num2, op), carries them through STAGES registered slots, and presents them at the ALU inputs.
- Supports global stall and flush, full bubble collapse, and in-order delivery.
- Flags reserved opcodes (3'b110, 3'b111) so downstream logic can discard their zero results.

Parameters:
- STAGES, 4, number of pipeline slots; legal values 1..8.
- W1, 8, num1 width.
- W2, 32, num2 width.
- OPW, 3, opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  pipe accepts the request this cycle.
- in_num1  input  W1  operand 1.
- in_num2  input  W2  operand 2.
- in_op  input  OPW  ALU opcode.
- stall  input  1  freeze all slots.
- flush  input  1  discard all in-flight entries.
- out_valid  output  1  operand set presented to the ALU.
- out_ready  input  1  consumer takes the operand set.
- out_num1  output  W1  to ALU num1.
- out_num2  output  W2  to ALU num2.
- out_op  output  OPW  to ALU op.
- out_rsvd  output  1  out_op is 3'b110 or 3'b111.
- occupancy  output  4  number of valid slots, 0..STAGES.

Behaviour:
- **Storage:** slot k (0 = input end, STAGES-1 = output end) holds a valid bit v[k] and the payload {num1, num2, op, rsvd}. rsvd is computed at entry as op[2] & op[1].
- **Reset** (rst_n = 0 at a clk edge): all v[k] = 0 and all payloads = 0. Hence out_valid = 0, out_num1/out_num2/out_op = 0, out_rsvd = 0, occupancy = 0. Reset has priority over flush, stall and handshakes, and drops any in-flight entry.
- **Ready chain** (combinational):
  - rdy[STAGES-1] = !v[STAGES-1] | out_ready.
  - rdy[k] = !v[k] | rdy[k+1].
- **Handshakes:**
  - in_ready = rdy[0] & !stall & !flush.
  - out_valid = v[STAGES-1] & !stall.
  - Output transfer occurs when out_valid & out_ready.
- **Advance** (no stall, no flush): slot k loads from slot k-1 when rdy[k]. Slot 0 loads the input when in_valid & in_ready. A slot that gives its entry away and receives nothing clears v.
- **Bubble collapse:** an entry moves into any empty slot ahead of it every cycle.
- **Latency:** exactly STAGES cycles from input accept to out_valid when the pipe is empty and out_ready = 1.
- **Throughput:** 1 entry per cycle with out_ready held at 1.
- **Backpressure:** while out_valid & !out_ready, out_num1/out_num2/out_op/out_rsvd stay stable. Upstream slots keep filling until all STAGES slots are valid, then in_ready = 0.
- **Full with simultaneous events:** if the pipe is full and out_ready = 1, in_ready = 1 in the same cycle (pass-through); occupancy stays STAGES.
- **Stall** (flush = 0): every register holds its value, in_ready = 0 and out_valid = 0, so no transfer occurs on either side.
- **Flush:**
  - At the next edge all v[k] are cleared; payloads are not required to clear.
  - flush has priority over stall and over acceptance: in_ready = 0 in the flush cycle.
  - out_valid follows v[STAGES-1] & !stall during the flush cycle, so an output handshake in that cycle is a completed transfer.
- **Occupancy:** combinational popcount of the v[k] bits; it is never greater than STAGES.
- **Order and integrity:** entries leave strictly in acceptance order. No entry is duplicated or lost except by flush or reset.
- **Width rules:** payload fields are carried unmodified. Zero-extension of num1 is done by the ALU, not by this block.

Test Plan:
1. **Reset and latency:** drive rst_n = 0 for 2 cycles, then release; send in_valid = 1 for one cycle with num1 = 8'h05, num2 = 32'h3, op = 3'b000, out_ready = 1. Required: all outputs 0 during reset; out_valid rises exactly 4 cycles after accept carrying 05/3/000; the downstream ALU gives ans = 8.
2. **Streaming throughput:** send 8 back-to-back requests with num1 = 1..8 and op cycling 000..111, out_ready = 1. Required: in_ready stays 1; 8 consecutive out_valid cycles in order; out_rsvd = 1 only on the op = 110 and op = 111 entries.
3. **Backpressure:** hold out_ready = 0 and send 6 requests. Required: 4 are accepted, then in_ready = 0 and occupancy = 4, with the output held at the first entry. Raise out_ready: the remaining 2 requests are accepted in the same cycles as drains, and all 6 emerge in order.
4. **Stall:** with 3 entries in flight, assert stall for 3 cycles while in_valid = 1 and out_ready = 1. Required: in_ready = 0, out_valid = 0 and occupancy is constant during the stall; the pipe resumes afterwards with identical contents.
5. **Flush:** with the pipe full, assert flush and in_valid together for one cycle. Required: no input accepted; occupancy = 0 and out_valid = 0 the next cycle; the next request shows a full 4-cycle latency.
6. **Reset mid-operation:** pull rst_n low while 2 entries are in flight and out_ready = 0. Required: after the edge all outputs are 0 and occupancy = 0; no stale entry appears after release.
